div: RTL and testbench
======================

Name: div

Overview:
- Sequential restoring divider; the inverse of the team's shift-and-add multiplier.
- Loads a dividend/divisor pair and produces one quotient bit per clock, using shift-and-subtract.
- Presents quotient and remainder registers plus a busy/done/divide-by-zero status.
- Sits in the same arithmetic lab datapath as the multiplier and shares its load-strobe style of control.

Parameters:
- WIDTH, 4, operand width in bits; quotient and remainder are each WIDTH bits.

Ports:
- clk   input   1       clock, all state updates on rising edge
- rst   input   1       reset, asynchronous, active-low
- ld    input   1       load strobe; sampled on rising edge
- a     input   WIDTH   dividend
- b     input   WIDTH   divisor
- rq    output  WIDTH   quotient register
- rr    output  WIDTH   remainder register
- busy  output  1       high while iterating
- done  output  1       one-cycle pulse, result valid
- dz    output  1       divide-by-zero flag for last accepted operation

Behaviour:
- Reset (rst low, any time, asynchronous):
  - state=IDLE; rq, rr, busy, done, dz all 0; iteration counter 0.
  - Reset mid-operation aborts the division with no partial result retained.
- States: IDLE, RUN, DONE.
- IDLE or DONE with ld=1 at edge E0:
  - a, b latched; done cleared.
  - If b==0: next state DONE, rq=all ones, rr=a, dz=1. done is high for the cycle after E0; no RUN phase.
  - Else: dz=0; internal partial remainder P (WIDTH+1 bits) cleared; working dividend D=a; counter=0; next state RUN; busy=1.
- RUN, each edge (WIDTH iterations total):
  - P shifts left with the MSB of D shifted in; D shifts left.
  - Trial T = P - {0,b}. If T is non-negative, P=T and a 1 is shifted into the quotient; otherwise P is kept and a 0 is shifted in.
  - Counter increments.
  - On the WIDTH-th iteration edge (E0+WIDTH): rq=final quotient, rr=P[WIDTH-1:0], busy=0, next state DONE.
- Latency: done is high in the cycle following edge E0+WIDTH, i.e. WIDTH cycles after load (1 cycle for b==0).
- DONE: done=1 for exactly one cycle, then IDLE on the next edge unless ld=1, in which case a new operation is accepted (back-to-back allowed).
- ld while busy=1 is ignored; operands and progress are unaffected.
- rq, rr and dz hold their values from the end of the operation until the next accepted ld. During RUN, rq and rr hold the previous result (internal working registers are separate).
- a and b may change freely after the load edge.
- Unsigned: rq*b + rr == a and rr < b for every b != 0.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - a and b are two's complement. The magnitudes are divided by the same unsigned datapath.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncating division).
  - Sign correction is applied at the final register write, so latency is unchanged.
  - Most-negative / -1 gives rq=most-negative (wraps), rr=0.
  - b==0 gives rq=all ones (-1), rr=a, dz=1.
- Undefined: purely unsigned operation as above; no sign logic synthesized.

Test Plan:
- WIDTH=4, ld with a=13, b=3 -> busy high 4 cycles; done pulses once; rq=4, rr=1, dz=0.
- a=15, b=1 then a=3, b=9 (back-to-back, second ld in DONE cycle) -> first rq=15, rr=0; second rq=0, rr=3; each done exactly one cycle.
- a=7, b=0 -> done in the next cycle, dz=1, rq=4'b1111, rr=7, busy never high.
- a=12, b=5 loaded; ld with a=1, b=1 asserted 2 cycles later -> second ld ignored; result rq=2, rr=2.
- Start a=9, b=2; drive rst low mid-RUN for a partial cycle -> outputs 0 immediately, state IDLE; a fresh ld of a=9, b=2 yields rq=4, rr=1.
- DIV_SIGNED_EN: a=4'b1001 (-7), b=2 -> rq=4'b1101 (-3), rr=4'b1111 (-1); a=4'b1000, b=4'b1111 -> rq=4'b1000, rr=0.

Source files
------------

// File: rtl/div_if.sv
// div_if: load strobe, operands and result/status bundle for the divider.
interface div_if #(parameter int WIDTH = 4);
  logic ld;
  logic [WIDTH-1:0] a, b, rq, rr;
  logic busy, done, dz;
  modport master(output ld, a, b, input rq, rr, busy, done, dz);
  modport slave(input ld, a, b, output rq, rr, busy, done, dz);
endinterface

// File: rtl/div.sv
// div: sequential restoring divider, one quotient bit per clock via shift-and-subtract.
// Define DIV_SIGNED_EN for two's-complement operands with truncating division.
module div #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] p, d, q, bd, a_mag, b_mag, p_nxt, q_nxt, q_fin, r_fin;
  logic [WIDTH:0] ps;
  logic ge, ld_ok, last;
  assign ld_ok = bus.ld && state != RUN;
  assign last = state == RUN && cnt == CW'(WIDTH - 1);
  // remainder always stays below the divisor, so WIDTH bits hold it between steps
  assign ps = {p, d[WIDTH-1]};
  assign ge = ps >= {1'b0, bd};
  assign p_nxt = ge ? WIDTH'(ps - {1'b0, bd}) : ps[WIDTH-1:0];
  assign q_nxt = {q[WIDTH-2:0], ge};
`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign q_fin = neg_q ? -q_nxt : q_nxt;
  assign r_fin = neg_r ? -p_nxt : p_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (ld_ok) begin
      neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      neg_r <= bus.a[WIDTH-1];
    end
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
  assign q_fin = q_nxt;
  assign r_fin = p_nxt;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    bus.busy = state == RUN;
    bus.done = state == DONE;
    state_nxt = ld_ok ? (bus.b == '0 ? DONE : RUN) : state == DONE ? IDLE : last ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      p <= '0;
      d <= '0;
      q <= '0;
      bd <= '0;
      bus.rq <= '0;
      bus.rr <= '0;
      bus.dz <= 1'b0;
    end else if (ld_ok) begin
      bus.dz <= bus.b == '0;
      if (bus.b == '0) begin
        bus.rq <= '1;
        bus.rr <= bus.a;
      end else begin
        p <= '0;
        d <= a_mag;
        bd <= b_mag;
        cnt <= '0;
      end
    end else if (state == RUN) begin
      p <= p_nxt;
      d <= d << 1;
      q <= q_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        bus.rq <= q_fin;
        bus.rr <= r_fin;
      end
    end
endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for div; expected results queued at load, checked on done.
module tb_div;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vecs = 0;
  int errs = 0;
  logic [8:0] sb[$];
  div_if #(.WIDTH(4)) bus();
  div #(.WIDTH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q, r;
    if (y == 4'd0) begin
      q = 4'hF;
      r = x;
    end else begin
`ifdef DIV_SIGNED_EN
      int sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      q = 4'(sx / sy);
      r = 4'(sx % sy);
`else
      q = x / y;
      r = x % y;
`endif
    end
    return {q, r, y == 4'd0};
  endfunction

  always @(negedge clk)
    if (rst && bus.done) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("rq", bus.rq, e[8:5]);
        chk("rr", bus.rr, e[4:1]);
        chk("dz", bus.dz, e[0]);
      end
    end

  task automatic drive(input logic [3:0] x, input logic [3:0] y, input bit push);
    bus.ld = 1'b1;
    bus.a = x;
    bus.b = y;
    if (push) sb.push_back(model(x, y));
    @(negedge clk);
    bus.ld = 1'b0;
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int bc;
    bc = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      if (bus.busy) bc++;
      @(negedge clk);
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy_cycles"}, bc, exp_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ld = 1'b0;
    bus.a = '0;
    bus.b = '0;
    @(negedge clk);
    chk("rst_rq", bus.rq, 0);
    chk("rst_rr", bus.rr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.dz, 0);
    rst = 1'b1;
    @(negedge clk);
    drive(13, 3, 1);
    wait_done("t13_3", 4);
    @(negedge clk);
    chk("t13_3_done_once", bus.done, 0);
    drive(15, 1, 1);
    wait_done("t15_1", 4);
    drive(3, 9, 1);
    chk("b2b_done_drop", bus.done, 0);
    wait_done("t3_9", 4);
    @(negedge clk);
    chk("t3_9_done_once", bus.done, 0);
    drive(7, 0, 1);
    wait_done("t7_0", 0);
    @(negedge clk);
    chk("t7_0_done_once", bus.done, 0);
    chk("t7_0_dz_hold", bus.dz, 1);
    drive(12, 5, 1);
    @(negedge clk);
    drive(1, 1, 0);
    wait_done("t12_5_ign", 2);
    @(negedge clk);
    drive(9, 2, 1);
    @(negedge clk);
    chk("run_hold_rq", bus.rq, 2);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    chk("arst_rq", bus.rq, 0);
    chk("arst_rr", bus.rr, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_dz", bus.dz, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("arst_idle_busy", bus.busy, 0);
    chk("arst_idle_done", bus.done, 0);
    drive(9, 2, 1);
    wait_done("t9_2", 4);
`ifdef DIV_SIGNED_EN
    @(negedge clk);
    drive(4'b1001, 4'd2, 1);
    wait_done("sgn_m7_2", 4);
    drive(4'b1000, 4'b1111, 1);
    wait_done("sgn_m8_m1", 4);
`endif
    for (int k = 0; k < 24; k++) begin
      logic [3:0] x, y;
      x = 4'($urandom);
      y = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      drive(x, y, 1);
      wait_done("rnd", y == 4'd0 ? 0 : 4);
    end
    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
